counter_modn: RTL



---
 rtl/counter_modn.sv | 82 ++++++++
 1 files changed

// File: rtl/counter_modn.sv
// Parametrised modulo-MOD up/down counter with load/clear, wrap or one-shot mode and a cascade carry chain.
// Optional step prescaler enabled by defining COUNTER_MODN_PRESCALE_EN.
module counter_modn #(
  parameter int     WIDTH    = 4,
  parameter longint MOD      = 10,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cin,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             cout,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || MOD > (longint'(1) << WIDTH) ||
      PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_param
    $error("counter_modn: parameter out of legal range");
  end

  logic             tick;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] term;

  function automatic logic [WIDTH-1:0] wrap_step(input logic [WIDTH-1:0] v, input logic up);
    if (up) return (v == MAX_VAL) ? '0 : v + 1'b1;
    else    return (v == '0) ? MAX_VAL : v - 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

`ifdef COUNTER_MODN_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] p;

  assign tick = (p == PW'(PRESCALE - 1));

  // prescaler only advances while the stage itself is enabled
  always_ff @(posedge clk) begin
    if (!rstn)          p <= '0;
    else if (clr | load) p <= '0;
    else if (en & cin)  p <= tick ? '0 : p + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  assign step    = en & cin & tick;
  assign term    = up_dn ? MAX_VAL : '0;
  assign at_term = (cnt == term);
  // Combinational so a whole cascade advances on the same edge
  assign cout    = rstn & step & at_term & ~done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= clamp(load_val);
      done <= 1'b0;
    end else if (step) begin
      // one-shot: hold at terminal and latch done; once done, stay frozen
      if (mode && (done || at_term)) done <= 1'b1;
      else                           cnt  <= wrap_step(cnt, up_dn);
    end
  end

endmodule
